// File: rtl/line_pkg.sv
// line_pkg: shared types and constants for the scanline line scheduler.
//   state_t     : scheduler FSM encoding
//   W_BITS      : width/height field width
//   COLOR_BITS  : color field width
//   CNT_BITS    : beat counter width (holds 640 x 480)
//   SCREEN_W/H  : frame geometry used for the default beat count
package line_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_VSYNC = 2'd1,
        ARM        = 2'd2,
        RUN        = 2'd3
    } state_t;

    localparam int W_BITS     = 10;
    localparam int COLOR_BITS = 16;
    localparam int CNT_BITS   = 19;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin first-valid finder.
//   valid : per-slot valid bits
//   base  : last granted slot; search runs base+1, base+2, ... ending at base
//   found : some slot is valid
//   idx   : first valid slot in search order (base when none found)
module rr_pick #(
    parameter int N  = 4,
    parameter int AW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [AW-1:0] base,
    output logic          found,
    output logic [AW-1:0] idx
);

    // Walk offsets from farthest to nearest so the nearest valid slot is the
    // last one assigned; offset N truncates to base itself, checked last.
    always_comb begin
        found = 1'b0;
        idx   = base;
        for (int i = N; i >= 1; i--) begin
            if (valid[base + AW'(i)]) begin
                found = 1'b1;
                idx   = base + AW'(i);
            end
        end
    end

endmodule

// File: rtl/line_sched.sv
// line_sched: frame-level sequencer for the scanline line-drawing engine.
//   clk, rst_n        : clock, asynchronous active-low reset
//   enable            : scheduling enable
//   vsync             : single-cycle frame-start pulse
//   cfg_we/addr/...   : host write port for descriptor slots {valid, w, h, color}
//   eng_fifo_write    : monitor of the engine's FIFO writes (one beat each)
//   eng_trigger       : one-cycle engine start pulse
//   eng_w/h/color     : descriptor latched for the running frame
//   cur_desc          : slot being drawn
//   busy              : high in ARM or RUN
//   frame_done        : pulse on the last pixel beat
//   overrun           : pulse when vsync arrives while busy
//   timeout           : pulse when the engine stalls for WDOG cycles
module line_sched import line_pkg::*; #(
    parameter int NDESC  = 4,
    parameter int PIXELS = SCREEN_W * SCREEN_H,
    parameter int WDOG   = 65535,
    parameter int AW     = $clog2(NDESC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  vsync,
    input  logic                  cfg_we,
    input  logic [AW-1:0]         cfg_addr,
    input  logic                  cfg_valid,
    input  logic [W_BITS-1:0]     cfg_w,
    input  logic [W_BITS-1:0]     cfg_h,
    input  logic [COLOR_BITS-1:0] cfg_color,
    input  logic                  eng_fifo_write,
    output logic                  eng_trigger,
    output logic [W_BITS-1:0]     eng_w,
    output logic [W_BITS-1:0]     eng_h,
    output logic [COLOR_BITS-1:0] eng_color,
    output logic [AW-1:0]         cur_desc,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overrun,
    output logic                  timeout
);

    localparam int WD_W = $clog2(WDOG + 1);

    logic [NDESC-1:0]      tv;
    logic [W_BITS-1:0]     tw [NDESC];
    logic [W_BITS-1:0]     th [NDESC];
    logic [COLOR_BITS-1:0] tc [NDESC];
    logic [NDESC-1:0]      usable;
    state_t                state, nxt;
    logic [AW-1:0]         ptr, pick;
    logic                  found, beat, last, wd_exp, start;
    logic [CNT_BITS-1:0]   cnt;
    logic [WD_W-1:0]       wdog;

    // A zero-width line never produces beats, so it can never be scheduled.
    always_comb begin
        usable = '0;
        for (int i = 0; i < NDESC; i++)
            usable[i] = tv[i] && (tw[i] != '0);
    end

    rr_pick #(.N(NDESC), .AW(AW)) u_pick (
        .valid(usable),
        .base (ptr),
        .found(found),
        .idx  (pick)
    );

    assign beat        = (state == RUN) && eng_fifo_write;
    assign last        = beat && (cnt == CNT_BITS'(PIXELS - 1));
    assign wd_exp      = (state == RUN) && !eng_fifo_write && (wdog == WD_W'(WDOG - 1));
    assign start       = (state == WAIT_VSYNC) && enable && vsync && found;
    assign eng_trigger = (state == ARM);
    assign busy        = (state == ARM) || (state == RUN);
    assign frame_done  = last;
    assign timeout     = wd_exp;
    assign overrun     = vsync && busy;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:       nxt = enable ? WAIT_VSYNC : IDLE;
            WAIT_VSYNC: nxt = !enable ? IDLE : (start ? ARM : WAIT_VSYNC);
            ARM:        nxt = RUN;
            RUN:        nxt = (last || wd_exp) ? (enable ? WAIT_VSYNC : IDLE) : RUN;
            default:    nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tv <= '0;
            for (int i = 0; i < NDESC; i++) begin
                tw[i] <= '0;
                th[i] <= '0;
                tc[i] <= '0;
            end
        end else if (cfg_we) begin
            tv[cfg_addr] <= cfg_valid;
            tw[cfg_addr] <= cfg_w;
            th[cfg_addr] <= cfg_h;
            tc[cfg_addr] <= cfg_color;
        end
    end

    // Engine outputs are registered copies so host writes during RUN
    // cannot disturb the frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            eng_w     <= '0;
            eng_h     <= '0;
            eng_color <= '0;
            cur_desc  <= '0;
            cnt       <= '0;
            wdog      <= '0;
        end else begin
            state <= nxt;
            if (start) begin
                eng_w     <= tw[pick];
                eng_h     <= th[pick];
                eng_color <= tc[pick];
                cur_desc  <= pick;
                ptr       <= pick;
            end
            if (state == ARM)
                cnt <= '0;
            else if (beat)
                cnt <= cnt + 1'b1;
            if (state == ARM || beat)
                wdog <= '0;
            else if (state == RUN)
                wdog <= wdog + 1'b1;
        end
    end

endmodule

// File: tb/tb_line_sched.sv
// tb_line_sched: scoreboard bench for line_sched; stimulus pushes expected
// output events, a negedge monitor pops and compares them.
module tb_line_sched;

    localparam int ND  = 4;
    localparam int PIX = 40;
    localparam int WD  = 100;

    logic        clk, rst_n, enable, vsync, cfg_we, cfg_valid, eng_fifo_write;
    logic [1:0]  cfg_addr, cur_desc;
    logic [9:0]  cfg_w, cfg_h, eng_w, eng_h;
    logic [15:0] cfg_color, eng_color;
    logic        eng_trigger, busy, frame_done, overrun, timeout;

    line_sched #(.NDESC(ND), .PIXELS(PIX), .WDOG(WD)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .vsync(vsync),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid),
        .cfg_w(cfg_w), .cfg_h(cfg_h), .cfg_color(cfg_color),
        .eng_fifo_write(eng_fifo_write), .eng_trigger(eng_trigger),
        .eng_w(eng_w), .eng_h(eng_h), .eng_color(eng_color),
        .cur_desc(cur_desc), .busy(busy), .frame_done(frame_done),
        .overrun(overrun), .timeout(timeout)
    );

    typedef struct {
        int          cyc;
        logic        trig, done, tmo, ovr;
        logic [1:0]  desc;
        logic [9:0]  w, h;
        logic [15:0] color;
    } ev_t;

    ev_t q[$];
    ev_t e;
    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    int  last_beat_cyc = 0;
    bit  ok;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(int c, logic tr, logic dn, logic tm, logic ov,
                                 logic [1:0] d, logic [9:0] w, logic [9:0] h, logic [15:0] col);
        ev_t x;
        x.cyc = c; x.trig = tr; x.done = dn; x.tmo = tm; x.ovr = ov;
        x.desc = d; x.w = w; x.h = h; x.color = col;
        q.push_back(x);
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (eng_trigger || frame_done || timeout || overrun)) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: cyc %0d trig %b done %b tmo %b ovr %b, expected no event",
                         cyc, eng_trigger, frame_done, timeout, overrun);
            end else begin
                e  = q.pop_front();
                ok = (e.cyc == cyc) && (e.trig == eng_trigger) && (e.done == frame_done) &&
                     (e.tmo == timeout) && (e.ovr == overrun) &&
                     (!e.trig || (e.desc == cur_desc && e.w == eng_w && e.h == eng_h && e.color == eng_color));
                if (!ok) begin
                    n_fail++;
                    $display("FAIL event: got cyc %0d trig %b done %b tmo %b ovr %b desc %0d w %0d h %0d col %h; expected cyc %0d trig %b done %b tmo %b ovr %b desc %0d w %0d h %0d col %h",
                             cyc, eng_trigger, frame_done, timeout, overrun, cur_desc, eng_w, eng_h, eng_color,
                             e.cyc, e.trig, e.done, e.tmo, e.ovr, e.desc, e.w, e.h, e.color);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic v, input logic [9:0] w,
                      input logic [9:0] h, input logic [15:0] c);
        cfg_we = 1'b1; cfg_addr = a; cfg_valid = v; cfg_w = w; cfg_h = h; cfg_color = c;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic start_frame(input logic [1:0] d, input logic [9:0] w,
                               input logic [9:0] h, input logic [15:0] c);
        push(cyc + 1, 1'b1, 1'b0, 1'b0, 1'b0, d, w, h, c);
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
    endtask

    task automatic vsync_none();
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
    endtask

    task automatic send_beats(input int nb, input int ovr_at);
        for (int i = 0; i < nb; i++) begin
            eng_fifo_write = 1'b1;
            vsync = (i == ovr_at);
            if (i == ovr_at || i == PIX - 1)
                push(cyc, 1'b0, i == PIX - 1, 1'b0, i == ovr_at, 2'd0, 10'd0, 10'd0, 16'd0);
            last_beat_cyc = cyc;
            tick();
        end
        eng_fifo_write = 1'b0;
        vsync = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_outs", {eng_trigger, frame_done, overrun, timeout}, 0);
        check("rst_eng", {eng_w, eng_h, eng_color, cur_desc}, 0);
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b0; vsync = 1'b0; cfg_we = 1'b0; cfg_addr = '0;
        cfg_valid = 1'b0; cfg_w = '0; cfg_h = '0; cfg_color = '0; eng_fifo_write = 1'b0;
        tick();
        do_reset();

        // 1: single slot, full frame
        wr(2'd2, 1'b1, 10'd640, 10'd480, 16'h07E0);
        enable = 1'b1;
        tick();
        start_frame(2'd2, 10'd640, 10'd480, 16'h07E0);
        check("busy_run", busy, 1);
        send_beats(PIX, -1);
        check("busy_after_done", busy, 0);

        // 2: round robin skipping invalid slot 2
        do_reset();
        wr(2'd0, 1'b1, 10'd100, 10'd50, 16'h1111);
        wr(2'd1, 1'b1, 10'd200, 10'd60, 16'h2222);
        wr(2'd3, 1'b1, 10'd300, 10'd70, 16'h3333);
        send_beats(3, -1);
        start_frame(2'd1, 10'd200, 10'd60, 16'h2222);
        send_beats(PIX, -1);
        start_frame(2'd3, 10'd300, 10'd70, 16'h3333);
        send_beats(PIX, -1);
        start_frame(2'd0, 10'd100, 10'd50, 16'h1111);
        send_beats(PIX, -1);

        // 3: zero-width slot is never scheduled
        do_reset();
        wr(2'd1, 1'b1, 10'd0, 10'd20, 16'h5555);
        vsync_none();
        tick();
        check("busy_w0", busy, 0);

        // 4: overrun mid-run, overrun on last beat, single slot reuse
        wr(2'd3, 1'b1, 10'd320, 10'd240, 16'hF800);
        start_frame(2'd3, 10'd320, 10'd240, 16'hF800);
        send_beats(PIX, 10);
        start_frame(2'd3, 10'd320, 10'd240, 16'hF800);
        send_beats(PIX, PIX - 1);
        check("busy_ovr_last", busy, 0);
        start_frame(2'd3, 10'd320, 10'd240, 16'hF800);
        send_beats(PIX, -1);

        // 5: watchdog timeout after 10 beats
        start_frame(2'd3, 10'd320, 10'd240, 16'hF800);
        send_beats(10, -1);
        push(last_beat_cyc + WD, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 10'd0, 10'd0, 16'd0);
        repeat (WD + 2) tick();
        check("busy_after_tmo", busy, 0);
        start_frame(2'd3, 10'd320, 10'd240, 16'hF800);
        enable = 1'b0;
        send_beats(PIX, -1);
        vsync_none();
        check("busy_idle", busy, 0);
        enable = 1'b1;
        tick();

        // 6: reset mid-run clears table
        start_frame(2'd3, 10'd320, 10'd240, 16'hF800);
        send_beats(5, -1);
        do_reset();
        vsync_none();
        check("busy_after_rst", busy, 0);
        wr(2'd0, 1'b1, 10'd64, 10'd32, 16'hABCD);
        start_frame(2'd0, 10'd64, 10'd32, 16'hABCD);
        send_beats(PIX, -1);

        repeat (5) tick();
        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/line_sched.md
Name: line_sched

Overview:
- Frame-level sequencer for the scanline line-drawing engine.
- Holds a small table of line descriptors (w, h, color), written by a host configuration port.
- On each frame start (vsync), selects the next valid descriptor round-robin, presents it to the engine and pulses the engine trigger.
- Counts the engine's FIFO writes to detect frame completion, with a watchdog for stalled engines.

Parameters:
NDESC, 4, number of descriptor slots (power of 2, 2..16)
PIXELS, 307200, FIFO beats per frame (640 x 480)
WDOG, 65535, max clk cycles between engine FIFO writes before timeout

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  scheduling enable
vsync  in  1  single-cycle frame-start pulse from video timing
cfg_we  in  1  descriptor write strobe
cfg_addr  in  log2(NDESC)  descriptor slot
cfg_valid  in  1  slot valid bit written with descriptor
cfg_w  in  10  line width
cfg_h  in  10  line height
cfg_color  in  16  line color
eng_fifo_write  in  1  monitor of the engine's fifo_write
eng_trigger  out  1  one-cycle start pulse to engine
eng_w  out  10  latched width to engine
eng_h  out  10  latched height to engine
eng_color  out  16  latched color to engine
cur_desc  out  log2(NDESC)  slot being drawn
busy  out  1  high in ARM or RUN
frame_done  out  1  one-cycle pulse on last pixel beat
overrun  out  1  one-cycle pulse: vsync arrived while busy
timeout  out  1  one-cycle pulse: watchdog expired

Behaviour:

Clock and reset
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: all outputs 0, descriptor table all invalid, round-robin pointer 0, state IDLE.
- Reset mid-frame aborts immediately. No trigger is issued until a vsync after reset release.

Descriptor table
- cfg_we writes {valid, w, h, color} to slot cfg_addr at the clock edge; writes are accepted in any state.
- A slot with w == 0 is treated as invalid. The engine would never terminate on it.
- Engine outputs are registered copies, so table writes during RUN never disturb the running frame.

State machine
- IDLE -> WAIT_VSYNC when enable = 1.
- WAIT_VSYNC, on vsync:
  - Search slots ptr+1, ptr+2, ... wrapping, ending at ptr itself (round-robin; after reset the search starts at slot 1, with slot 0 checked last).
  - If a valid slot k is found: latch eng_w/eng_h/eng_color/cur_desc from slot k, set ptr = k, go to ARM.
  - If no valid slot exists: stay in WAIT_VSYNC, no trigger.
- ARM:
  - eng_trigger = 1 for exactly this cycle, i.e. the cycle after vsync.
  - Clear the beat counter (19 bits) and the watchdog.
  - Go to RUN.
- RUN:
  - Each eng_fifo_write increments the beat counter and clears the watchdog.
  - A beat while the counter is at PIXELS-1 pulses frame_done in that same cycle. Next state: WAIT_VSYNC if enable = 1, else IDLE.
  - Watchdog reaching WDOG with no beat pulses timeout. Next state as for frame_done; frame_done is not asserted.

Boundary conditions
- vsync in ARM or RUN: overrun pulses; the vsync is otherwise ignored (not queued).
- vsync in the same cycle as frame_done: counts as an overrun and is not used to start a new frame. The next frame starts on the following vsync.
- eng_fifo_write in WAIT_VSYNC or IDLE is ignored.
- enable deasserted in RUN: the current frame completes, then the block enters IDLE.
- enable deasserted in WAIT_VSYNC: the block enters IDLE next cycle.
- Single valid slot: that slot is reused every frame.

Decomposition:
- Shared package line_pkg:
  - state encoding (IDLE, WAIT_VSYNC, ARM, RUN)
  - descriptor field widths (W_BITS = 10, COLOR_BITS = 16)
  - SCREEN_W = 640, SCREEN_H = 480
- One natural sub-module, rr_pick: a combinational round-robin first-valid finder over NDESC valid bits from a base pointer. Outputs found and idx.
- Table, counter, watchdog and FSM stay in line_sched.

Test Plan:
1. Reset, write slot 2 {w=640, h=480, color=0x07E0} valid, enable=1, vsync -> eng_trigger exactly 1 cycle after vsync; eng_w=640, eng_h=480, cur_desc=2; after 307200 eng_fifo_write beats, frame_done pulses on the last beat and busy drops.
2. Slots 0, 1, 3 valid; slot 2 invalid -> over three successive frames cur_desc = 1, 3, 0 (ptr starts at 0, slot 2 skipped).
3. Slot 1 written with w=0, valid=1, and it is the only slot -> vsync produces no trigger; busy stays 0.
4. vsync pulsed mid-RUN at beat 1000 -> overrun pulses 1 cycle; no trigger; the frame still finishes at 307200 beats.
5. Stop eng_fifo_write after 10 beats with WDOG=100 -> timeout pulses on cycle 100 after the last beat; no frame_done; state returns to WAIT_VSYNC.
6. rst_n low mid-RUN, then release -> all outputs 0; the table is invalid; rewrite a slot and vsync -> normal trigger.
